// File: rtl/time_dmr_issue_scheduler.sv
// Time-DMR front-end scheduler: arbitrates fresh vs retry requests, allocates IDs,
// and issues every accepted operation twice (original, then replay) downstream.
module time_dmr_issue_scheduler #(
  parameter int DataWidth    = 16,
  parameter int OpgroupWidth = 2,
  parameter int IDSize       = 5,
  parameter int LockTimeout  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    new_valid_i,
  output logic                    new_ready_o,
  input  logic [DataWidth-1:0]    new_data_i,
  input  logic [OpgroupWidth-1:0] new_operation_i,
  input  logic                    retry_valid_i,
  output logic                    retry_ready_o,
  input  logic [DataWidth-1:0]    retry_data_i,
  input  logic [OpgroupWidth-1:0] retry_operation_i,
  input  logic [IDSize-1:0]       retry_id_i,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  output logic [DataWidth-1:0]    issue_data_o,
  output logic [OpgroupWidth-1:0] issue_operation_o,
  output logic [IDSize-1:0]       issue_id_o,
  output logic                    issue_replay_o,
  input  logic                    retire_valid_i,
  input  logic [IDSize-1:0]       retire_id_i,
  output logic [IDSize:0]         free_count_o,
  output logic                    retire_error_o
);
  localparam int Pool = 2**IDSize;
  localparam int SW   = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;
  localparam logic [IDSize:0] PoolCnt = (IDSize+1)'(Pool);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE_A = 2'd1;
  localparam logic [1:0] ISSUE_B = 2'd2;

  typedef struct packed {
    logic [DataWidth-1:0]    data;
    logic [OpgroupWidth-1:0] op;
    logic [IDSize-1:0]       id;
  } txn_t;

  logic [1:0]      state;
  txn_t            txn;
  logic [Pool-1:0] free_bits, free_next;
  logic [IDSize:0] free_count;
  logic [SW-1:0]   starve_cnt;
  logic            err;
  logic [IDSize-1:0] alloc_id;
  logic idle, fresh_ok, starved, retire_hit, handshake;

  assign idle     = (state == IDLE);
  assign starved  = (starve_cnt == SW'(LockTimeout));
  assign fresh_ok = idle && new_valid_i && (free_count != '0);
  // Retry has priority unless a fresh request has waited LockTimeout retry grants.
  assign retry_ready_o = idle && retry_valid_i && !(fresh_ok && starved);
  assign new_ready_o   = fresh_ok && !retry_ready_o;

  assign retire_hit = retire_valid_i && !free_bits[retire_id_i];
  assign handshake  = issue_valid_o && issue_ready_i;

  // Lowest-numbered free ID, taken from the pre-retire bitmap.
  always_comb begin
    alloc_id = '0;
    for (int i = Pool - 1; i >= 0; i--)
      if (free_bits[i]) alloc_id = IDSize'(i);
  end

  always_comb begin
    free_next = free_bits;
    if (new_ready_o) free_next[alloc_id] = 1'b0;
    if (retire_hit)  free_next[retire_id_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      txn        <= '0;
      free_bits  <= '1;
      free_count <= PoolCnt;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      free_bits  <= free_next;
      free_count <= free_count - (IDSize+1)'(new_ready_o) + (IDSize+1)'(retire_hit);
      if (retire_valid_i && free_bits[retire_id_i]) err <= 1'b1;

      if (idle) begin
        if (new_ready_o || !new_valid_i) starve_cnt <= '0;
        else if (retry_ready_o && !starved) starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (retry_ready_o) begin
            txn   <= '{data: retry_data_i, op: retry_operation_i, id: retry_id_i};
            state <= ISSUE_A;
          end else if (new_ready_o) begin
            txn   <= '{data: new_data_i, op: new_operation_i, id: alloc_id};
            state <= ISSUE_A;
          end
        end
        ISSUE_A: if (handshake) state <= ISSUE_B;
        ISSUE_B: if (handshake) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign issue_valid_o     = (state == ISSUE_A) || (state == ISSUE_B);
  assign issue_replay_o    = (state == ISSUE_B);
  assign issue_data_o      = txn.data;
  assign issue_operation_o = txn.op;
  assign issue_id_o        = txn.id;
  assign free_count_o      = free_count;
  assign retire_error_o    = err;
endmodule

// File: tb/tb_time_dmr_issue_scheduler.sv
// Directed bench for time_dmr_issue_scheduler: arbitration, ID pool, stalls, retire errors, reset.
module tb_time_dmr_issue_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        new_valid = 0, retry_valid = 0, issue_ready = 0, retire_valid = 0;
  logic        new_ready, retry_ready, issue_valid, issue_replay, retire_error;
  logic [15:0] new_data = '0, retry_data = '0, issue_data;
  logic [1:0]  new_op = '0, retry_op = '0, issue_op;
  logic [4:0]  retry_id = '0, issue_id, retire_id = '0;
  logic [5:0]  free_count;

  int checks = 0;
  int failures = 0;

  time_dmr_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .new_valid_i(new_valid), .new_ready_o(new_ready), .new_data_i(new_data),
    .new_operation_i(new_op),
    .retry_valid_i(retry_valid), .retry_ready_o(retry_ready), .retry_data_i(retry_data),
    .retry_operation_i(retry_op), .retry_id_i(retry_id),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_data_o(issue_data),
    .issue_operation_o(issue_op), .issue_id_o(issue_id), .issue_replay_o(issue_replay),
    .retire_valid_i(retire_valid), .retire_id_i(retire_id),
    .free_count_o(free_count), .retire_error_o(retire_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (issue_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(issue_valid), 32'd0);
  endtask

  initial begin
    string seq;
    int n;
    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_replay", 32'(issue_replay), 0);
    chk("rst_id", 32'(issue_id), 0);
    chk("rst_data", 32'(issue_data), 0);
    chk("rst_new_ready", 32'(new_ready), 0);
    chk("rst_retry_ready", 32'(retry_ready), 0);
    chk("rst_free", 32'(free_count), 32);
    chk("rst_err", 32'(retire_error), 0);
    rst_n = 1'b0;
    @(negedge clk);

    // Single fresh request
    new_valid = 1; new_op = 2; new_data = 16'h005A; issue_ready = 1;
    #1 chk("t1_new_ready", 32'(new_ready), 1);
    @(negedge clk);
    chk("t1_a_valid", 32'(issue_valid), 1);
    chk("t1_a_replay", 32'(issue_replay), 0);
    chk("t1_a_id", 32'(issue_id), 0);
    chk("t1_a_data", 32'(issue_data), 32'h5A);
    chk("t1_a_op", 32'(issue_op), 2);
    chk("t1_free", 32'(free_count), 31);
    chk("t1_busy_ready", 32'({new_ready, retry_ready}), 0);
    new_valid = 0;
    @(negedge clk);
    chk("t1_b_valid", 32'(issue_valid), 1);
    chk("t1_b_replay", 32'(issue_replay), 1);
    chk("t1_b_id", 32'(issue_id), 0);
    @(negedge clk);
    chk("t1_idle", 32'(issue_valid), 0);

    // Stall in ISSUE_A for 4 cycles
    new_valid = 1; new_op = 1; new_data = 16'h1234; issue_ready = 0;
    @(negedge clk);
    new_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall_valid", 32'(issue_valid), 1);
      chk("t4_stall_replay", 32'(issue_replay), 0);
      chk("t4_stall_id", 32'(issue_id), 1);
      chk("t4_stall_data", 32'(issue_data), 32'h1234);
      if (i == 3) issue_ready = 1;
      @(negedge clk);
    end
    chk("t4_b_replay", 32'(issue_replay), 1);
    chk("t4_b_id", 32'(issue_id), 1);
    chk("t4_b_data", 32'(issue_data), 32'h1234);
    @(negedge clk);
    chk("t4_idle", 32'(issue_valid), 0);
    chk("t4_free", 32'(free_count), 30);

    // Starvation bound: expect R R R R R F R
    new_valid = 1; new_data = 16'hAAAA; new_op = 3;
    retry_valid = 1; retry_data = 16'hBEEF; retry_op = 0; retry_id = 9;
    #1 chk("t2_retry_first", 32'({retry_ready, new_ready}), 32'b10);
    seq = "";
    n = 0;
    while (seq.len() < 7 && n < 40) begin
      @(negedge clk);
      n++;
      if (issue_valid && !issue_replay) begin
        if (issue_id == 9 && issue_data == 16'hBEEF) seq = {seq, "R"};
        else if (issue_id == 2 && issue_data == 16'hAAAA) seq = {seq, "F"};
        else seq = {seq, "?"};
      end
    end
    chk("t2_sequence", 32'(seq == "RRRRRFR"), 1);
    new_valid = 0; retry_valid = 0;
    wait_idle("t2_drain");
    chk("t2_free", 32'(free_count), 29);

    // Exhaust the pool
    new_valid = 1; new_data = 16'h0F0F;
    n = 0;
    while (free_count != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_exhaust", 32'(free_count), 0);
    chk("t3_last_id", 32'(issue_id), 31);
    wait_idle("t3_drain");
    chk("t3_new_blocked", 32'(new_ready), 0);
    retry_valid = 1; retry_id = 4; retry_data = 16'h4444;
    #1 chk("t3_retry_ok", 32'({retry_ready, new_ready}), 32'b10);
    @(negedge clk);
    retry_valid = 0;
    chk("t3_retry_id", 32'(issue_id), 4);
    chk("t3_retry_data", 32'(issue_data), 32'h4444);
    wait_idle("t3_retry_drain");
    retire_valid = 1; retire_id = 7;
    @(negedge clk);
    retire_valid = 0;
    chk("t3_retire_free", 32'(free_count), 1);
    #1 chk("t3_new_ready", 32'(new_ready), 1);
    @(negedge clk);
    new_valid = 0;
    chk("t3_realloc_id", 32'(issue_id), 7);
    chk("t3_realloc_free", 32'(free_count), 0);
    wait_idle("t3_realloc_drain");

    // Duplicate retire
    retire_valid = 1; retire_id = 3;
    @(negedge clk);
    chk("t5_first_free", 32'(free_count), 1);
    chk("t5_first_err", 32'(retire_error), 0);
    @(negedge clk);
    retire_valid = 0;
    chk("t5_dup_err", 32'(retire_error), 1);
    chk("t5_dup_free", 32'(free_count), 1);
    @(negedge clk);
    chk("t5_sticky", 32'(retire_error), 1);
    // Simultaneous allocate and retire
    new_valid = 1; new_data = 16'h5555; retire_valid = 1; retire_id = 5;
    @(negedge clk);
    new_valid = 0; retire_valid = 0;
    chk("t5_alloc_id", 32'(issue_id), 3);
    chk("t5_alloc_free", 32'(free_count), 1);
    wait_idle("t5_drain");

    // Reset during ISSUE_B
    new_valid = 1; new_data = 16'h6666;
    @(negedge clk);
    new_valid = 0;
    chk("t6_a_id", 32'(issue_id), 5);
    @(negedge clk);
    chk("t6_b_replay", 32'(issue_replay), 1);
    rst_n = 1;
    #1;
    chk("t6_rst_valid", 32'(issue_valid), 0);
    chk("t6_rst_free", 32'(free_count), 32);
    chk("t6_rst_err", 32'(retire_error), 0);
    @(negedge clk);
    rst_n = 0;
    new_valid = 1; new_data = 16'h7777;
    @(negedge clk);
    new_valid = 0;
    chk("t6_post_id", 32'(issue_id), 0);
    chk("t6_post_replay", 32'(issue_replay), 0);
    chk("t6_post_free", 32'(free_count), 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/time_dmr_issue_scheduler.md
# time_dmr_issue_scheduler

Front-end scheduler for the time-DMR retry datapath: arbitrates between fresh upstream operations and retry requests coming back from the fault-detection path, allocates a transaction ID per fresh operation, and issues every accepted operation twice back-to-back (original copy, then replay copy) into the redundant pipeline. Retries have priority, bounded by an anti-starvation counter. IDs are returned by the downstream voter through a retire port.

## Interface
- DataWidth, 16, payload width
- OpgroupWidth, 2, operation/opgroup selector width, passed through unchanged
- IDSize, 5, transaction ID width; ID pool holds 2**IDSize entries
- LockTimeout, 5, max consecutive retry grants while a fresh request waits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- new_valid_i / new_ready_o  in/out  1  fresh-request handshake
- new_data_i  in  DataWidth  fresh payload
- new_operation_i  in  OpgroupWidth  fresh opgroup
- retry_valid_i / retry_ready_o  in/out  1  retry-request handshake
- retry_data_i  in  DataWidth  retry payload
- retry_operation_i  in  OpgroupWidth  retry opgroup
- retry_id_i  in  IDSize  ID already owned by the retried transaction
- issue_valid_o / issue_ready_i  out/in  1  downstream issue handshake
- issue_data_o  out  DataWidth; issue_operation_o  out  OpgroupWidth; issue_id_o  out  IDSize
- issue_replay_o  out  1  0 = original copy, 1 = replay copy
- retire_valid_i  in  1  downstream frees an ID this cycle
- retire_id_i  in  IDSize  ID being freed
- free_count_o  out  IDSize+1  number of free IDs
- retire_error_o  out  1  sticky: retire of an already-free ID

## Operation
- States: IDLE, ISSUE_A (original), ISSUE_B (replay).
- IDLE: new_ready_o / retry_ready_o may be high; at most one asserted per cycle; both low in ISSUE_A/ISSUE_B.
- Grant in IDLE: retry wins if retry_valid_i, unless new_valid_i and starve_cnt == LockTimeout, then fresh wins. Fresh additionally requires free_count_o > 0; with no free ID new_ready_o = 0 and retry may be granted regardless of starve_cnt.
- starve_cnt: +1 on each retry grant while new_valid_i is high; cleared on fresh grant or when new_valid_i is low in IDLE; saturates at LockTimeout.
- Fresh grant: allocate lowest-numbered free ID, clear its free bit, latch payload/op/ID. Retry grant: latch payload/op/retry_id_i, pool untouched.
- On grant -> ISSUE_A. ISSUE_A handshake -> ISSUE_B (same data/op/ID, replay=1). ISSUE_B handshake -> IDLE.
- Retire: sets free bit of retire_id_i next cycle. Already free: no change, retire_error_o set until reset.
- Allocation and retire in same cycle: allocation uses pre-update bitmap; free_count_o = previous - alloc + valid_retire.
- Overflow impossible: free_count_o never exceeds 2**IDSize.

## Timing
- Reset: issue_valid_o=0, issue_replay_o=0, issue_data_o/operation/id=0, new_ready_o=0, retry_ready_o=0, free_count_o=2**IDSize, retire_error_o=0, starve_cnt=0, all IDs free, state IDLE.
- Ready outputs are combinational from state, input valids, starve_cnt, free_count_o; no path from issue_ready_i.
- Grant in cycle N -> issue_valid_o high from N+1; payload, ID, op, replay stable while valid and not ready.
- Minimum: 3 cycles per transaction (grant, A, B), both issue copies in consecutive cycles when issue_ready_i held high.
- issue_valid_o never drops without a handshake; reset mid-issue drops it immediately and returns every ID to the pool.

## Test plan
- Reset release, single fresh request op=2 data=0x5A, issue_ready_i=1 -> ID 0 issued replay=0 at N+1, replay=1 at N+2, free_count_o 32->31.
- Continuous retry_valid_i plus waiting fresh request, LockTimeout=5 -> exactly 5 retry grants, then fresh grant, starve_cnt cleared.
- 32 fresh grants with no retire -> free_count_o=0, new_ready_o low, retry still granted; retire ID 7 -> next fresh gets ID 7.
- issue_ready_i low 4 cycles in ISSUE_A then high -> payload/ID stable throughout, replay copy follows next cycle.
- Retire ID 3 while ID 3 free -> retire_error_o=1 sticky, free_count_o unchanged; simultaneous alloc+retire -> count unchanged.
- Assert rst_n during ISSUE_B -> issue_valid_o=0 immediately, free_count_o=32, state IDLE.
